llc_input_sched: RTL and testbench
==================================

Name: llc_input_sched

Overview:
Input scheduler for the LLC transaction pipeline (DECODE/READ/LOOKUP/PROCESS/UPDATE). On each decode strobe it picks one transaction source by fixed priority, with anti-starvation between CPU and DMA requests. Sources are: coherence responses, testbench reset/flush, resumed DMA reads and writes, CPU requests, and DMA requests. It handshakes the chosen input channel and holds a one-hot grant until the pipeline reports completion. It also sequences the set-by-set walk for reset and flush and signals completion on the rst_tb_done channel.

Parameters:
SET_BITS, 9, width of set index; walk covers sets 0..2^SET_BITS-1
STARVE_MAX, 4, maximum consecutive CPU-request grants while a DMA request waits

Ports:
clk  in  1  clock
rst  in  1  reset
decode_en  in  1  pipeline in DECODE; request an arbitration
txn_done  in  1  one-cycle pulse: UPDATE of current transaction finished
rsp_in_valid / rsp_in_ready  in / out  1 / 1  coherence response channel
rst_tb_valid / rst_tb_ready  in / out  1 / 1  testbench reset/flush channel
rst_tb_data  in  1  1 = reset (invalidate all), 0 = flush
req_in_valid / req_in_ready  in / out  1 / 1  CPU request channel
dma_req_in_valid / dma_req_in_ready  in / out  1 / 1  DMA request channel
req_stall  in  1  CPU requests blocked (set conflict)
recall_pending  in  1  recall outstanding
dma_read_pending  in  1  partially served DMA read awaiting resume
dma_write_pending  in  1  partially served DMA write awaiting resume
grant  out  8  one-hot: [0] rst_to_resume [1] flush_to_resume [2] rst_to_get [3] rsp_to_get [4] dma_read_to_resume [5] dma_write_to_resume [6] req_to_get [7] dma_req_to_get
walk_set  out  SET_BITS  set index for resume grants [0]/[1]
rst_tb_done_valid / rst_tb_done_ready  out / in  1 / 1  walk-complete channel
rst_tb_done  out  1  completion value; 1 when valid

Behaviour:
- Reset rst is asynchronous and active-low; clock is clk. On reset: FSM=IDLE, grant=0, all readies=0, walk_active=0, walk_set=0, starve_cnt=0, rst_tb_done_valid=0, rst_tb_done=0.
- Reset mid-operation abandons any grant or walk. The pending handshake is not completed.
- FSM states: IDLE, GRANT, BUSY, DONE_OUT.
- IDLE with decode_en=1: evaluate priority and latch grant. If a source is selected, go to GRANT next cycle. If nothing is selected, grant stays 0 and FSM stays IDLE.
- Priority, highest first:
  1. walk_active: grant [0] if walk_mode=reset, [1] if flush.
  2. rsp_in_valid: [3].
  3. rst_tb_valid and !recall_pending and !dma_read_pending and !dma_write_pending: [2].
  4. dma_read_pending and !recall_pending: [4].
  5. dma_write_pending and !recall_pending: [5].
  6. CPU vs DMA:
     - req_ok = req_in_valid and !req_stall.
     - dma_ok = dma_req_in_valid and !dma_read_pending and !dma_write_pending.
     - Both ok: grant [7] if starve_cnt==STARVE_MAX, otherwise [6].
     - Only one ok: grant that one.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on a [6] grant while dma_ok=1.
  - Clears on any [7] grant, or whenever dma_ok=0 at decode.
- GRANT lasts exactly 1 cycle. The matching ready is high for that cycle only: rsp_in_ready for [3], rst_tb_ready for [2], req_in_ready for [6], dma_req_in_ready for [7]. Resume grants assert no ready. Sources hold valid until ready, so the transfer completes in GRANT. Then go to BUSY.
- grant is held stable from GRANT through BUSY until the cycle after txn_done. In that cycle, grant clears to 0 and the FSM returns to IDLE, or goes to DONE_OUT if the walk has finished.
- A txn_done in IDLE or GRANT is ignored.
- On txn_done of a [2] grant: walk_active=1, walk_mode=rst_tb_data latched at accept, walk_set=0.
- On txn_done of a [0]/[1] grant:
  - If walk_set != all-ones: walk_set increments.
  - If walk_set == all-ones: walk_active=0, walk_set wraps to 0, go to DONE_OUT.
- DONE_OUT: rst_tb_done_valid=1 and rst_tb_done=1, held until rst_tb_done_ready. Clear both on handshake and return to IDLE. decode_en is ignored in DONE_OUT.
- A walk of 2^SET_BITS sets produces exactly 2^SET_BITS resume grants. rsp_in preempts nothing once a walk is active, because walk priority is highest.

Test Plan:
- Reset: rst low mid-BUSY with grant=0x40 -> after release: grant=0, all readies=0, FSM in IDLE, rst_tb_done_valid=0.
- rsp_in_valid=req_in_valid=dma_req_in_valid=1, decode_en -> grant=0x08; rsp_in_ready pulses 1 cycle; req/dma readies stay 0.
- req and DMA always valid, 6 decode/txn_done rounds, STARVE_MAX=4 -> grants 0x40 ×4, 0x80, 0x40.
- rst_tb_valid=1, rst_tb_data=1, SET_BITS=2 -> grant 0x04, then 0x01 with walk_set 0,1,2,3, then rst_tb_done_valid=1. With rst_tb_done_ready held low 5 cycles, valid is held; it clears after the handshake.
- recall_pending=1, dma_read_pending=1, req valid -> grant=0x40. Drop recall_pending -> next decode grant=0x10.
- req_stall=1 with only req valid -> decode_en leaves grant=0, FSM in IDLE, req_in_ready never asserted.

Source files
------------

// File: rtl/llc_input_sched_if.sv
// Handshake and status bundle between the LLC input scheduler and its sources/pipeline.
interface llc_input_sched_if #(
    parameter int unsigned SET_BITS = 9
) ();
    logic                decode_en;
    logic                txn_done;
    logic                rsp_in_valid;
    logic                rsp_in_ready;
    logic                rst_tb_valid;
    logic                rst_tb_ready;
    logic                rst_tb_data;
    logic                req_in_valid;
    logic                req_in_ready;
    logic                dma_req_in_valid;
    logic                dma_req_in_ready;
    logic                req_stall;
    logic                recall_pending;
    logic                dma_read_pending;
    logic                dma_write_pending;
    logic [7:0]          grant;
    logic [SET_BITS-1:0] walk_set;
    logic                rst_tb_done_valid;
    logic                rst_tb_done_ready;
    logic                rst_tb_done;

    modport slave (
        input  decode_en, txn_done, rsp_in_valid, rst_tb_valid, rst_tb_data,
               req_in_valid, dma_req_in_valid, req_stall, recall_pending,
               dma_read_pending, dma_write_pending, rst_tb_done_ready,
        output rsp_in_ready, rst_tb_ready, req_in_ready, dma_req_in_ready,
               grant, walk_set, rst_tb_done_valid, rst_tb_done
    );

    modport master (
        output decode_en, txn_done, rsp_in_valid, rst_tb_valid, rst_tb_data,
               req_in_valid, dma_req_in_valid, req_stall, recall_pending,
               dma_read_pending, dma_write_pending, rst_tb_done_ready,
        input  rsp_in_ready, rst_tb_ready, req_in_ready, dma_req_in_ready,
               grant, walk_set, rst_tb_done_valid, rst_tb_done
    );
endinterface

// File: rtl/llc_input_sched.sv
// LLC input scheduler: fixed-priority source pick with CPU/DMA anti-starvation,
// one-hot grant held until txn_done, and the set-by-set reset/flush walk.
module llc_input_sched #(
    parameter int unsigned SET_BITS   = 9,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    llc_input_sched_if.slave      bus
);
    localparam int unsigned GRANT_W = 8;
    localparam int unsigned CNT_W   = $clog2(STARVE_MAX + 1);

    localparam int unsigned G_RST_RES   = 0;
    localparam int unsigned G_FLUSH_RES = 1;
    localparam int unsigned G_RST_GET   = 2;
    localparam int unsigned G_RSP_GET   = 3;
    localparam int unsigned G_DMA_RD    = 4;
    localparam int unsigned G_DMA_WR    = 5;
    localparam int unsigned G_REQ_GET   = 6;
    localparam int unsigned G_DMA_GET   = 7;

    typedef enum logic [1:0] {IDLE, GRANT, BUSY, DONE_OUT} state_t;

    state_t               state;
    logic [GRANT_W-1:0]   grant_q;
    logic [SET_BITS-1:0]  walk_set_q;
    logic [CNT_W-1:0]     starve_q;
    logic                 walk_active_q;
    logic                 walk_mode_q;
    logic                 tb_mode_q;
    logic                 rsp_rdy_q, tb_rdy_q, req_rdy_q, dma_rdy_q;
    logic                 done_valid_q, done_q;

    logic                 req_ok_c;
    logic                 dma_ok_c;
    logic [GRANT_W-1:0]   sel_c;

    // Priority pick evaluated on each decode strobe
    always_comb begin
        sel_c    = '0;
        req_ok_c = bus.req_in_valid && !bus.req_stall;
        dma_ok_c = bus.dma_req_in_valid && !bus.dma_read_pending && !bus.dma_write_pending;
        if (walk_active_q) begin
            if (walk_mode_q) sel_c[G_RST_RES]   = 1'b1;
            else             sel_c[G_FLUSH_RES] = 1'b1;
        end else if (bus.rsp_in_valid) begin
            sel_c[G_RSP_GET] = 1'b1;
        end else if (bus.rst_tb_valid && !bus.recall_pending &&
                     !bus.dma_read_pending && !bus.dma_write_pending) begin
            sel_c[G_RST_GET] = 1'b1;
        end else if (bus.dma_read_pending && !bus.recall_pending) begin
            sel_c[G_DMA_RD] = 1'b1;
        end else if (bus.dma_write_pending && !bus.recall_pending) begin
            sel_c[G_DMA_WR] = 1'b1;
        end else if (req_ok_c && dma_ok_c) begin
            if (starve_q == CNT_W'(STARVE_MAX)) sel_c[G_DMA_GET] = 1'b1;
            else                                sel_c[G_REQ_GET] = 1'b1;
        end else if (req_ok_c) begin
            sel_c[G_REQ_GET] = 1'b1;
        end else if (dma_ok_c) begin
            sel_c[G_DMA_GET] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            grant_q       <= '0;
            walk_set_q    <= '0;
            starve_q      <= '0;
            walk_active_q <= 1'b0;
            walk_mode_q   <= 1'b0;
            tb_mode_q     <= 1'b0;
            rsp_rdy_q     <= 1'b0;
            tb_rdy_q      <= 1'b0;
            req_rdy_q     <= 1'b0;
            dma_rdy_q     <= 1'b0;
            done_valid_q  <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.decode_en) begin
                        if (sel_c != '0) begin
                            grant_q   <= sel_c;
                            rsp_rdy_q <= sel_c[G_RSP_GET];
                            tb_rdy_q  <= sel_c[G_RST_GET];
                            req_rdy_q <= sel_c[G_REQ_GET];
                            dma_rdy_q <= sel_c[G_DMA_GET];
                            state     <= GRANT;
                        end
                        // DMA starvation counter tracks only consecutive CPU wins over a waiting DMA
                        if (!dma_ok_c || sel_c[G_DMA_GET])
                            starve_q <= '0;
                        else if (sel_c[G_REQ_GET] && starve_q != CNT_W'(STARVE_MAX))
                            starve_q <= starve_q + CNT_W'(1);
                    end
                end
                GRANT: begin
                    rsp_rdy_q <= 1'b0;
                    tb_rdy_q  <= 1'b0;
                    req_rdy_q <= 1'b0;
                    dma_rdy_q <= 1'b0;
                    if (grant_q[G_RST_GET]) tb_mode_q <= bus.rst_tb_data;
                    state <= BUSY;
                end
                BUSY: begin
                    if (bus.txn_done) begin
                        grant_q <= '0;
                        state   <= IDLE;
                        if (grant_q[G_RST_GET]) begin
                            walk_active_q <= 1'b1;
                            walk_mode_q   <= tb_mode_q;
                            walk_set_q    <= '0;
                        end else if (grant_q[G_RST_RES] || grant_q[G_FLUSH_RES]) begin
                            if (walk_set_q == {SET_BITS{1'b1}}) begin
                                walk_active_q <= 1'b0;
                                walk_set_q    <= '0;
                                done_valid_q  <= 1'b1;
                                done_q        <= 1'b1;
                                state         <= DONE_OUT;
                            end else begin
                                walk_set_q <= walk_set_q + SET_BITS'(1);
                            end
                        end
                    end
                end
                DONE_OUT: begin
                    if (bus.rst_tb_done_ready) begin
                        done_valid_q <= 1'b0;
                        done_q       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant             = grant_q;
    assign bus.walk_set          = walk_set_q;
    assign bus.rsp_in_ready      = rsp_rdy_q;
    assign bus.rst_tb_ready      = tb_rdy_q;
    assign bus.req_in_ready      = req_rdy_q;
    assign bus.dma_req_in_ready  = dma_rdy_q;
    assign bus.rst_tb_done_valid = done_valid_q;
    assign bus.rst_tb_done       = done_q;
endmodule

// File: tb/tb_llc_input_sched.sv
// Scoreboard bench for llc_input_sched: directed rounds push expected grants, a monitor checks them.
module tb_llc_input_sched;
    localparam int unsigned SB = 2;

    typedef struct packed {
        logic [7:0]    grant;
        logic [3:0]    rdy;    // {dma_req, req, rst_tb, rsp}
        logic [SB-1:0] wset;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic done_exp_q[$];
    logic [7:0] prev_grant;

    llc_input_sched_if #(.SET_BITS(SB)) bus ();
    llc_input_sched #(.SET_BITS(SB), .STARVE_MAX(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [3:0] rdy_vec();
        return {bus.dma_req_in_ready, bus.req_in_ready, bus.rst_tb_ready, bus.rsp_in_ready};
    endfunction

    // Monitor: compares each newly presented grant and completion against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        logic d;
        if (!rst) begin
            prev_grant = '0;
        end else begin
            if (bus.grant != 8'h00 && prev_grant == 8'h00) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected got=%h", bus.grant);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.grant !== e.grant || rdy_vec() !== e.rdy || bus.walk_set !== e.wset) begin
                        errors++;
                        $display("FAIL grant_issue got grant=%h rdy=%b set=%0d want grant=%h rdy=%b set=%0d",
                                 bus.grant, rdy_vec(), bus.walk_set, e.grant, e.rdy, e.wset);
                    end
                end
            end else begin
                checks++;
                if (rdy_vec() !== 4'b0000) begin
                    errors++;
                    $display("FAIL ready_stray got=%b want=0000 grant=%h", rdy_vec(), bus.grant);
                end
                if (prev_grant != 8'h00 && bus.grant != 8'h00) begin
                    checks++;
                    if (bus.grant !== prev_grant) begin
                        errors++;
                        $display("FAIL grant_hold got=%h want=%h", bus.grant, prev_grant);
                    end
                end
            end
            if (bus.rst_tb_done_valid && bus.rst_tb_done_ready) begin
                checks++;
                if (done_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected got=%b", bus.rst_tb_done);
                end else begin
                    d = done_exp_q.pop_front();
                    if (bus.rst_tb_done !== d) begin
                        errors++;
                        $display("FAIL done_value got=%b want=%b", bus.rst_tb_done, d);
                    end
                end
            end
            prev_grant = bus.grant;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic push(input logic [7:0] g, input logic [3:0] r, input int unsigned s);
        exp_t e;
        e.grant = g;
        e.rdy   = r;
        e.wset  = SB'(s);
        exp_q.push_back(e);
    endtask

    // One decode -> GRANT -> BUSY -> txn_done round
    task automatic do_txn();
        @(posedge clk) #1 bus.decode_en = 1'b1;
        @(posedge clk) #1 bus.decode_en = 1'b0;
        @(posedge clk) #1 bus.txn_done  = 1'b1;
        @(posedge clk) #1 bus.txn_done  = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_grant"}, 32'(bus.grant), 32'h0);
        chk({tag, "_readies"}, 32'(rdy_vec()), 32'h0);
        chk({tag, "_done_valid"}, 32'(bus.rst_tb_done_valid), 32'h0);
        chk({tag, "_walk_set"}, 32'(bus.walk_set), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus.decode_en = 0; bus.txn_done = 0;
        bus.rsp_in_valid = 0; bus.rst_tb_valid = 0; bus.rst_tb_data = 0;
        bus.req_in_valid = 0; bus.dma_req_in_valid = 0; bus.req_stall = 0;
        bus.recall_pending = 0; bus.dma_read_pending = 0; bus.dma_write_pending = 0;
        bus.rst_tb_done_ready = 0;
        repeat (3) @(posedge clk);
        #1 chk_idle_outputs("por");
        rst = 1'b1;

        // Response beats CPU and DMA
        bus.rsp_in_valid = 1; bus.req_in_valid = 1; bus.dma_req_in_valid = 1;
        push(8'h08, 4'b0001, 0);
        do_txn();
        bus.rsp_in_valid = 0; bus.req_in_valid = 0; bus.dma_req_in_valid = 0;

        // Anti-starvation: four CPU wins, then DMA, then CPU again
        bus.req_in_valid = 1; bus.dma_req_in_valid = 1;
        for (int i = 0; i < 4; i++) push(8'h40, 4'b0100, 0);
        push(8'h80, 4'b1000, 0);
        push(8'h40, 4'b0100, 0);
        for (int i = 0; i < 6; i++) do_txn();
        bus.req_in_valid = 0; bus.dma_req_in_valid = 0;

        // Reset walk over 4 sets, then the completion handshake
        bus.rst_tb_valid = 1; bus.rst_tb_data = 1;
        push(8'h04, 4'b0010, 0);
        do_txn();
        bus.rst_tb_valid = 0; bus.rst_tb_data = 0;
        for (int k = 0; k < 4; k++) begin
            push(8'h01, 4'b0000, k);
            do_txn();
        end
        chk("walk_done_valid", 32'(bus.rst_tb_done_valid), 32'h1);
        chk("walk_done_value", 32'(bus.rst_tb_done), 32'h1);
        done_exp_q.push_back(1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk) #1 chk("done_held", 32'(bus.rst_tb_done_valid), 32'h1);
        end
        bus.rst_tb_done_ready = 1;
        @(posedge clk) #1 bus.rst_tb_done_ready = 0;
        chk("done_cleared_valid", 32'(bus.rst_tb_done_valid), 32'h0);
        chk("done_cleared_value", 32'(bus.rst_tb_done), 32'h0);

        // Recall blocks the DMA read resume until it drops
        bus.recall_pending = 1; bus.dma_read_pending = 1; bus.req_in_valid = 1;
        push(8'h40, 4'b0100, 0);
        do_txn();
        bus.recall_pending = 0;
        push(8'h10, 4'b0000, 0);
        do_txn();
        bus.req_in_valid = 0; bus.dma_read_pending = 0;

        // Stalled CPU request yields no grant
        bus.req_in_valid = 1; bus.req_stall = 1;
        @(posedge clk) #1 bus.decode_en = 1;
        @(posedge clk) #1 bus.decode_en = 0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_grant", 32'(bus.grant), 32'h0);
            chk("stall_req_ready", 32'(bus.req_in_ready), 32'h0);
            @(posedge clk) #1;
        end
        bus.req_stall = 0;
        push(8'h40, 4'b0100, 0);
        do_txn();
        bus.req_in_valid = 0;

        // Reset asserted while BUSY with a CPU grant
        bus.req_in_valid = 1;
        push(8'h40, 4'b0100, 0);
        @(posedge clk) #1 bus.decode_en = 1;
        @(posedge clk) #1 bus.decode_en = 0;
        @(posedge clk) #1 chk("busy_grant", 32'(bus.grant), 32'h40);
        rst = 1'b0;
        #1 chk("async_rst_grant", 32'(bus.grant), 32'h0);
        bus.req_in_valid = 0;
        @(posedge clk);
        @(posedge clk) #1 rst = 1'b1;
        chk_idle_outputs("midrst");
        bus.rsp_in_valid = 1;
        push(8'h08, 4'b0001, 0);
        do_txn();
        bus.rsp_in_valid = 0;
        repeat (2) @(posedge clk);

        chk("grant_queue_drained", 32'(exp_q.size()), 32'h0);
        chk("done_queue_drained", 32'(done_exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
